mips_store_align: RTL

- Store-side counterpart of the ALU's LWL/LWR load-merge path: takes a decoded store (SB, SH, SW, SWL, SWR), the effective byte address and the rt value.
- Produces a word-aligned memory write with byte enables and lane-shifted write data.
- Sits between the datapath and the data-memory bus, and stalls the CPU while the memory asserts waitrequest.
- Little-endian byte lanes: lane k = writedata[8k+7:8k].

---
 rtl/mips_store_align.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mips_store_align.sv
`timescale 1ns/1ps
// Store alignment unit: turns SB/SH/SW/SWL/SWR into one word-aligned bus write
// with byte enables, stalling on waitrequest and reporting alignment/bus errors.
module mips_store_align #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  output logic        done,
  output logic        addr_error,
  output logic        bus_error
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

  state_t        state;
  state_t        next_state;
  logic [1:0]    b;
  logic          legal;
  logic          accept;
  logic          limit_hit;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wd;
  logic [CW-1:0] wait_cnt;
  logic          err_bus;

  assign b         = req_addr[1:0];
  assign accept    = req_valid && (state == IDLE);
  assign limit_hit = (WAIT_LIMIT != 0) && mem_waitrequest && ((wait_cnt + CW'(1)) == LIMIT);

  // SWL moves the high bytes of rt down into lanes b..0; SWR moves the low bytes up into lanes 3..b.
  always_comb begin
    lane_be = 4'b0000;
    lane_wd = 32'h0;
    legal   = 1'b1;
    case (req_op)
      3'b000: begin
        lane_be = 4'b0001 << b;
        lane_wd = {4{req_data[7:0]}};
      end
      3'b001: begin
        legal   = ~b[0];
        lane_be = 4'b0011 << b;
        lane_wd = {2{req_data[15:0]}};
      end
      3'b010: begin
        legal   = (b == 2'b00);
        lane_be = 4'b1111;
        lane_wd = req_data;
      end
      3'b011: begin
        lane_be = (4'b0010 << b) - 4'b0001;
        lane_wd = req_data >> {~b, 3'b000};
      end
      3'b100: begin
        lane_be = 4'b1111 << b;
        lane_wd = req_data << {b, 3'b000};
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = legal ? WRITE : ERR;
      WRITE: begin
        if (!mem_waitrequest) next_state = DONE;
        else if (limit_hit)   next_state = ERR;
      end
      DONE:  next_state = IDLE;
      ERR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_write  = (state == WRITE);
    done       = (state == DONE) || (state == ERR);
    addr_error = (state == ERR) && !err_bus;
    bus_error  = (state == ERR) && err_bus;
  end

  // Bus fields are captured only on a legal accept so they stay frozen while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address    <= 32'h0;
      mem_byteenable <= 4'b0000;
      mem_writedata  <= 32'h0;
      wait_cnt       <= '0;
      err_bus        <= 1'b0;
    end else begin
      if (accept && legal) begin
        mem_address    <= {req_addr[31:2], 2'b00};
        mem_byteenable <= lane_be;
        mem_writedata  <= lane_wd;
      end
      if (accept)
        wait_cnt <= '0;
      else if (state == WRITE && mem_waitrequest)
        wait_cnt <= wait_cnt + CW'(1);
      if (next_state == ERR)
        err_bus <= (state == WRITE);
    end
  end

endmodule
